// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, mie/mip bit
// positions and the default drain-timeout limit.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        FLUSH
    } trap_state_t;

    localparam int MSIE_BIT          = 3;
    localparam int MTIE_BIT          = 7;
    localparam int MEIE_BIT          = 11;
    localparam int DRAIN_MAX_DEFAULT = 255;
    localparam int DRAIN_W           = 8;

    // Source vectors are packed {external, software, timer}; highest index wins.
    function automatic logic [2:0] pick_cause(input logic [2:0] pend);
        logic [2:0] onehot;
        onehot = 3'b000;
        if (pend[2]) begin
            onehot = 3'b100;
        end else if (pend[1]) begin
            onehot = 3'b010;
        end else if (pend[0]) begin
            onehot = 3'b001;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt request lines.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks exception vs. interrupt at the M/W boundary, waits for
// the buses to drain, pulses the csr commit strobes, then flushes the front end.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trint_raw,
    input  logic        swint_raw,
    input  logic        exint_raw,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie_bits,
    input  logic        m_valid,
    input  logic        m_ex,
    input  logic        m_csr_or_mret,
    input  logic        stall_w,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    output logic        hold_pipe,
    output logic        has_ex,
    output logic        has_int,
    output logic        trint,
    output logic        swint,
    output logic        exint,
    output logic        flush_all,
    output logic        drain_timeout,
    output logic [31:0] trap_count
);

    localparam logic [DRAIN_W-1:0] DRAIN_TOP  = DRAIN_W'(DRAIN_MAX);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

    trap_state_t         state_reg, state_next;
    logic                is_int_reg, is_int_next;
    logic [2:0]          cause_reg, cause_next;
    logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
    logic                timeout_reg, timeout_next;
    logic                mask_reg;
    logic [31:0]         count_reg;

    logic                exint_s;
    logic [2:0]          pend;
    logic                bus_busy;
    logic                trap;

    irq_sync #(.WIDTH(1)) u_exint_sync (
        .clk   (clk),
        .reset (reset),
        .d     (exint_raw),
        .q     (exint_s)
    );

    // csr regs land one edge after a commit/CSR write, so the enables seen in
    // that following cycle are stale and pending interrupts are ignored then.
    assign pend     = (mstatus_mie && !mask_reg) ? ({exint_s, swint_raw, trint_raw} & mie_bits) : 3'b000;
    assign bus_busy = ibus_busy || dbus_busy;
    assign trap     = (state_reg == IDLE) && m_valid && !stall_w && ((pend != 3'b000) || m_ex);

    always_comb begin
        state_next     = state_reg;
        is_int_next    = is_int_reg;
        cause_next     = cause_reg;
        drain_cnt_next = drain_cnt_reg;
        timeout_next   = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (trap) begin
                    is_int_next    = (pend != 3'b000);
                    cause_next     = pick_cause(pend);
                    drain_cnt_next = '0;
                    state_next     = bus_busy ? DRAIN : COMMIT;
                end
            end
            DRAIN: begin
                if (drain_cnt_reg != DRAIN_TOP) begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
                if (!bus_busy) begin
                    state_next = COMMIT;
                end else if (drain_cnt_reg == DRAIN_LAST) begin
                    // This cycle brings the counter to the limit: give up on the bus.
                    state_next   = COMMIT;
                    timeout_next = 1'b1;
                end
            end
            COMMIT:  state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are gated by reset so a reset landing mid-trap never leaks a pulse.
    always_comb begin
        hold_pipe = 1'b0;
        has_ex    = 1'b0;
        has_int   = 1'b0;
        flush_all = 1'b0;
        if (!reset) begin
            hold_pipe = trap || (state_reg == DRAIN) || (state_reg == COMMIT);
            has_ex    = (state_reg == COMMIT) && !is_int_reg;
            has_int   = (state_reg == COMMIT) && is_int_reg;
            flush_all = (state_reg == FLUSH);
        end
        {exint, swint, trint} = has_int ? cause_reg : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            is_int_reg    <= 1'b0;
            cause_reg     <= 3'b000;
            drain_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
            mask_reg      <= 1'b0;
            count_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            is_int_reg    <= is_int_next;
            cause_reg     <= cause_next;
            drain_cnt_reg <= drain_cnt_next;
            timeout_reg   <= timeout_next;
            mask_reg      <= (state_reg == COMMIT) || (m_valid && m_csr_or_mret);
            if (state_reg == COMMIT) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign drain_timeout = timeout_reg;
    assign trap_count    = count_reg;

endmodule
